// File: rtl/sum_bcd_display_pkg.sv
// Shared definitions for the BCD sum display: FSM encoding and 7-segment patterns.
package sum_bcd_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Map a decimal digit to its segment pattern; non-decimal codes show blank
  function automatic logic [6:0] seg7_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sum_bcd_display_seg7_decoder.sv
// One 7-segment digit decoder: BCD digit plus blank flag to active-low segments.
module seg7_decoder
  import sum_bcd_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank overrides the digit so suppressed leading zeros go fully dark
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) seg = seg7_of(digit);
  end

endmodule

// File: rtl/sum_bcd_display.sv
// Sequential binary-to-BCD (double-dabble) converter driving active-low 7-seg displays.
// A sum is accepted in IDLE, shifted one bit per clock, then latched into the display registers.
module sum_bcd_display
  import sum_bcd_display_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int DIGITS   = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      sum_in,
  input  logic                  sum_valid,
  output logic                  sum_ready,
  output logic                  done,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int BCD_W = DIGITS * 4;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t                   state_reg, state_next;
  logic [SR_W-1:0]          sr_reg, sr_next, sr_adj;
  logic [CNT_W-1:0]         count_reg, count_next;
  logic [DIGITS-1:0][3:0]   bcd_digit;
  logic [DIGITS-1:0][3:0]   digit_reg;
  logic [DIGITS-1:0]        blank_reg, blank_next;
  logic                     done_reg;
  logic                     zero_run;

  genvar gi;

  // Add-3 correction on every BCD nibble (4-bit wrap, no carry between nibbles);
  // the binary part passes through untouched
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = sr_reg[WIDTH + 4*gi +: 4];
      assign sr_adj[WIDTH + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      assign bcd_digit[gi] = nib;
    end
  endgenerate
  assign sr_adj[WIDTH-1:0] = sr_reg[WIDTH-1:0];

  // State register; reset aborts any conversion in flight
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state: accept in IDLE, shift WIDTH times, one UPDATE cycle, back to IDLE
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:   if (sum_valid) state_next = ST_SHIFT;
      ST_SHIFT:  if (count_reg == CNT_W'(1)) state_next = ST_UPDATE;
      ST_UPDATE: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: only IDLE can take a new sum
  always_comb begin
    sum_ready = (state_reg == ST_IDLE);
  end

  // Shift register / bit counter next values: load on handshake, adjust-then-shift in SHIFT
  always_comb begin
    sr_next    = sr_reg;
    count_next = count_reg;
    if (state_reg == ST_IDLE && sum_valid) begin
      sr_next    = {{BCD_W{1'b0}}, sum_in};
      count_next = CNT_W'(WIDTH);
    end else if (state_reg == ST_SHIFT) begin
      sr_next    = {sr_adj[SR_W-2:0], 1'b0};
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Conversion datapath registers
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg    <= '0;
      count_reg <= '0;
    end else begin
      sr_reg    <= sr_next;
      count_reg <= count_next;
    end
  end

  // Leading-zero blanking: digit k>=1 goes dark when it and every higher digit are zero
  always_comb begin
    zero_run   = 1'b1;
    blank_next = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run      = zero_run & (bcd_digit[k] == 4'd0);
      blank_next[k] = (BLANK_LZ != 0) && (k != 0) && zero_run;
    end
  end

  // Display registers change only when leaving UPDATE, so HEX never shows a partial value
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      digit_reg <= '0;
      blank_reg <= '1;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= (state_reg == ST_UPDATE);
      if (state_reg == ST_UPDATE) begin
        digit_reg <= bcd_digit;
        blank_reg <= blank_next;
      end
    end
  end

  assign done = done_reg;

  // One decoder per display, fed straight from the display registers
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dec
      seg7_decoder u_dec (
        .digit (digit_reg[gi]),
        .blank (blank_reg[gi]),
        .seg   (HEX[7*gi +: 7])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sum_bcd_display.sv
// Self-checking bench for sum_bcd_display: directed cases plus randomized traffic
// checked every cycle against a decimal/timing model of the display.
module tb_sum_bcd_display;

  localparam int WIDTH    = 6;
  localparam int DIGITS   = 2;
  localparam int BLANK_LZ = 1;
  localparam int HW       = 7 * DIGITS;

  logic              CLOCK_50  = 1'b0;
  logic              rst_n     = 1'b0;
  logic [WIDTH-1:0]  sum_in    = '0;
  logic              sum_valid = 1'b0;
  logic              sum_ready;
  logic              done;
  logic [HW-1:0]     HEX;

  int checks = 0;
  int errors = 0;

  sum_bcd_display #(
    .WIDTH    (WIDTH),
    .DIGITS   (DIGITS),
    .BLANK_LZ (BLANK_LZ)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .rst_n     (rst_n),
    .sum_in    (sum_in),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .done      (done),
    .HEX       (HEX)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference segment table
  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'b1000000;
      1: s = 7'b1111001;
      2: s = 7'b0100100;
      3: s = 7'b0110000;
      4: s = 7'b0011001;
      5: s = 7'b0010010;
      6: s = 7'b0000010;
      7: s = 7'b1111000;
      8: s = 7'b0000000;
      9: s = 7'b0010000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Expected display for a value, by decimal arithmetic
  function automatic logic [HW-1:0] hex_of(input int v);
    logic [HW-1:0] h;
    int p;
    h = '1;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      if (BLANK_LZ != 0 && k > 0 && v < p) h[7*k +: 7] = 7'h7F;
      else                                 h[7*k +: 7] = seg_of((v / p) % 10);
      p = p * 10;
    end
    return h;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: busy for WIDTH+1 edges after a handshake, then display shows the value
  logic           m_busy    = 1'b0;
  int             m_left    = 0;
  int             m_pending = 0;
  logic [HW-1:0]  m_hex     = '1;
  logic           m_done    = 1'b0;

  always @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_left = 0;
      m_hex  = '1;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_hex  = hex_of(m_pending);
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (sum_valid) begin
        m_pending = int'(sum_in);
        m_busy    = 1'b1;
        m_left    = WIDTH + 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge CLOCK_50) begin
    check("ready", 32'(sum_ready), 32'(!m_busy));
    check("done", 32'(done), 32'(m_done));
    check("hex", 32'(HEX), 32'(m_hex));
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (sum_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (sum_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: got %b expected 1", sum_ready);
    end
  endtask

  task automatic send(input int v);
    wait_ready();
    sum_in    = WIDTH'(v);
    sum_valid = 1'b1;
    tick();
    sum_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (done !== 1'b1 && n < 40);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: got %b expected 1", done);
    end
  endtask

  initial begin
    int n;

    // 1: reset state, then idle after release
    repeat (3) tick();
    check("rst_hex", 32'(HEX), 32'h3FFF);
    check("rst_ready", 32'(sum_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_hex", 32'(HEX), 32'h3FFF);
    check("idle_ready", 32'(sum_ready), 32'd1);
    check("idle_done", 32'(done), 32'd0);

    // 2: 63 -> "63", ready low WIDTH+1 clocks, single done pulse
    send(63);
    n = 0;
    while (sum_ready == 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check("ready_low_clks", 32'(n), 32'd7);
    check("done_63", 32'(done), 32'd1);
    check("hex_63", 32'(HEX), 32'({7'b0000010, 7'b0110000}));
    tick();
    check("done_pulse_end", 32'(done), 32'd0);

    // 3: 42 -> "42", held for 20 clocks with no done
    send(42);
    wait_done();
    check("hex_42", 32'(HEX), 32'({7'b0011001, 7'b0100100}));
    tick();
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      check("hold_done", 32'(done), 32'd0);
      check("hold_hex_42", 32'(HEX), 32'({7'b0011001, 7'b0100100}));
    end
    tick();

    // 4: leading-zero blanking
    send(0);
    wait_done();
    check("hex_0", 32'(HEX), 32'({7'h7F, 7'b1000000}));
    tick();
    send(9);
    wait_done();
    check("hex_9", 32'(HEX), 32'({7'h7F, 7'b0010000}));
    tick();

    // 5: valid while busy is ignored; back-to-back handshake in the IDLE cycle after UPDATE
    wait_ready();
    sum_in    = WIDTH'(17);
    sum_valid = 1'b1;
    tick();
    sum_in = WIDTH'(5);
    repeat (3) tick();
    sum_valid = 1'b0;
    wait_ready();
    sum_in    = WIDTH'(25);
    sum_valid = 1'b1;
    @(negedge CLOCK_50);
    check("b2b_done_17", 32'(done), 32'd1);
    check("hex_17", 32'(HEX), 32'({7'b1111001, 7'b1111000}));
    tick();
    sum_valid = 1'b0;
    check("b2b_busy", 32'(sum_ready), 32'd0);
    wait_done();
    check("hex_25", 32'(HEX), 32'({7'b0100100, 7'b0010010}));
    tick();

    // 6: reset mid-conversion blanks at once and produces no done
    send(50);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("abort_hex", 32'(HEX), 32'h3FFF);
    check("abort_ready", 32'(sum_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_still_blank", 32'(HEX), 32'h3FFF);
    send(1);
    wait_done();
    check("hex_1", 32'(HEX), 32'({7'h7F, 7'b1111001}));
    tick();

    // Randomized traffic, valid often held through busy periods
    for (int i = 0; i < 3000; i++) begin
      sum_valid = ($urandom_range(0, 3) != 0);
      sum_in    = WIDTH'($urandom);
      tick();
    end
    sum_valid = 1'b0;
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
